// File: rtl/g_macro_pkg.sv
// Shared definitions for the schematic gate macro library.
// Holds the reduction mode codes, the persistence filter state encoding
// and the reduction helper used by the N-input gate macros.
package g_macro_pkg;

  localparam int unsigned MODE_OR  = 0;
  localparam int unsigned MODE_AND = 1;
  localparam int unsigned MODE_XOR = 2;

  // Largest gate supported by g_reduce.
  localparam int unsigned MAX_WIDTH = 32;

  // Persistence filter states: output agrees with raw, or raw differs and is being counted.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } filt_state_e;

  // Reduce the low 'width' bits of 'term' with OR, AND or XOR; bits above 'width' are ignored.
  function automatic logic g_reduce(input logic [MAX_WIDTH-1:0] term,
                                    input int unsigned          width,
                                    input int unsigned          mode);
    logic r;
    r = (mode == MODE_AND);
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        case (mode)
          MODE_AND: r = r & term[i];
          MODE_XOR: r = r ^ term[i];
          default:  r = r | term[i];
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/g_sync_chain.sv
// Per-bit synchroniser chain for possibly asynchronous inputs.
// Ports:
//   CK  - clock, rising edge
//   RN  - asynchronous active-low reset, clears every stage
//   D   - WIDTH-bit input
//   Q   - D after STAGES flops; a straight wire when STAGES = 0
// The flops have no enable: they always sample.
module g_sync_chain #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign Q = D;
    end else begin : g_flops
      logic [WIDTH-1:0] stage_q [STAGES];

      // Shift register: stage 0 samples D, the last stage drives Q.
      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          for (int i = 0; i < int'(STAGES); i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= D;
          for (int i = 1; i < int'(STAGES); i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign Q = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/g_nlogic_filt.sv
// N-input gate with per-input inversion, selectable OR/AND/XOR reduction,
// optional input synchronisers and a persistence (glitch) filter.
// Ports:
//   CK  - clock, rising edge
//   RN  - asynchronous active-low reset
//   CE  - clock enable for filter state and Y (synchronisers ignore it)
//   D   - WIDTH gate inputs, may be asynchronous
//   Y   - filtered, registered gate result
//   YR  - unfiltered gate result taken straight from the synchroniser outputs
//   CHG - one-cycle pulse on the cycle Y toggles
module g_nlogic_filt
  import g_macro_pkg::*;
#(
  parameter int unsigned      WIDTH       = 3,
  parameter logic [WIDTH-1:0] INV_MASK    = {WIDTH{1'b1}},
  parameter int unsigned      MODE        = 0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILTER      = 4,
  parameter logic             RESET_VAL   = 1'b0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic             Y,
  output logic             YR,
  output logic             CHG
);

  localparam int unsigned CNT_W  = $clog2(FILTER + 1);
  localparam int unsigned FILL_W = (SYNC_STAGES > 0) ? $clog2(SYNC_STAGES + 1) : 1;

  // Reject illegal configurations at elaboration.
  generate
    if (MODE > MODE_XOR) begin : g_bad_mode
      $error("g_nlogic_filt: MODE must be 0 (OR), 1 (AND) or 2 (XOR)");
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("g_nlogic_filt: WIDTH must be 1..32");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
      $error("g_nlogic_filt: SYNC_STAGES must be 0..3");
    end
    if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
      $error("g_nlogic_filt: FILTER must be 1..255");
    end
  endgenerate

  logic [WIDTH-1:0]  ds;
  logic [WIDTH-1:0]  term;
  logic              raw;
  logic [FILL_W-1:0] fill_q;
  logic              fill_done;
  filt_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              y_d;
  logic              chg_d;

  g_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CK (CK),
    .RN (RN),
    .D  (D),
    .Q  (ds)
  );

  // Gate: invert selected inputs, then reduce.
  assign term = ds ^ INV_MASK;
  assign raw  = g_reduce(MAX_WIDTH'(term), WIDTH, MODE);
  assign YR   = raw;

  // After reset the synchroniser still holds reset zeros rather than real
  // input samples; qualification waits until the chain has refilled so the
  // full SYNC_STAGES + FILTER latency applies after every reset release.
  assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      fill_q <= '0;
    end else if (!fill_done) begin
      fill_q <= fill_q + FILL_W'(1);
    end
  end

  // Filter state, counter and registered outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      Y       <= RESET_VAL;
      CHG     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Y       <= y_d;
      CHG     <= chg_d;
    end
  end

  // Next state: count consecutive enabled cycles with raw != Y; toggle on the FILTER-th.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = Y;
    chg_d   = 1'b0;
    if (CE && fill_done) begin
      case (state_q)
        ST_STABLE: begin
          if (raw != Y) begin
            if (FILTER == 1) begin
              y_d   = raw;
              chg_d = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_QUAL;
            end
          end
        end
        ST_QUAL: begin
          if (raw == Y) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q >= CNT_W'(FILTER - 1)) begin
            y_d     = raw;
            chg_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_nlogic_filt.sv
// Bench for g_nlogic_filt: default (inverted-input OR), AND and XOR configurations,
// directed scenarios plus randomized traffic on the default instance against a
// run-length reference model.
module tb_g_nlogic_filt;

  localparam int S = 2;   // default synchroniser depth
  localparam int F = 4;   // default filter length

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, rn_aux, ce, ce_aux;
  logic [2:0] d_def;
  logic [3:0] d_and;
  logic [1:0] d_xor;
  logic       y_def, yr_def, chg_def;
  logic       y_and, yr_and, chg_and;
  logic       y_xor, yr_xor, chg_xor;

  int n_cmp = 0;
  int n_bad = 0;

  g_nlogic_filt u_def (
    .CK (clk), .RN (rn), .CE (ce), .D (d_def),
    .Y (y_def), .YR (yr_def), .CHG (chg_def)
  );

  g_nlogic_filt #(
    .WIDTH (4), .INV_MASK (4'h0), .MODE (1), .SYNC_STAGES (0), .FILTER (1)
  ) u_and (
    .CK (clk), .RN (rn_aux), .CE (ce_aux), .D (d_and),
    .Y (y_and), .YR (yr_and), .CHG (chg_and)
  );

  g_nlogic_filt #(
    .WIDTH (2), .INV_MASK (2'b00), .MODE (2)
  ) u_xor (
    .CK (clk), .RN (rn_aux), .CE (ce_aux), .D (d_xor),
    .Y (y_xor), .YR (yr_xor), .CHG (chg_xor)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model for the default instance: the input seen S edges ago,
  // and the number of consecutive enabled edges on which the gate disagreed with Y.
  logic [2:0] pipe[$];
  int         warm, run;
  logic       m_y, m_chg;

  // Inverted-input OR of three bits: true unless every input is high.
  function automatic logic gate_def(input logic [2:0] ds);
    return ds != 3'b111;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(3'b000);
    warm  = 0;
    run   = 0;
    m_y   = 1'b0;
    m_chg = 1'b0;
  endtask

  task automatic model_edge();
    logic raw;
    raw   = gate_def(pipe[0]);
    m_chg = 1'b0;
    if (warm < S) begin
      warm++;
    end else if (ce) begin
      if (raw != m_y) begin
        run++;
        if (run == F) begin
          m_y   = raw;
          m_chg = 1'b1;
          run   = 0;
        end
      end else begin
        run = 0;
      end
    end
    void'(pipe.pop_front());
    pipe.push_back(d_def);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".y"},   y_def,   m_y);
    check({tag, ".chg"}, chg_def, m_chg);
    check({tag, ".yr"},  yr_def,  gate_def(pipe[0]));
  endtask

  initial begin
    int nchg;
    int len;
    rn = 1'b0; rn_aux = 1'b0; ce = 1'b1; ce_aux = 1'b1;
    d_def = 3'b000; d_and = 4'h0; d_xor = 2'b00;
    model_reset();
    #12;
    check("rst.y",      y_def,   1'b0);
    check("rst.chg",    chg_def, 1'b0);
    check("rst.yr",     yr_def,  1'b1);
    check("rst.and_y",  y_and,   1'b0);
    check("rst.xor_y",  y_xor,   1'b0);
    check("rst.xor_yr", yr_xor,  1'b0);

    @(negedge clk);
    rn = 1'b1; rn_aux = 1'b1;

    // Power-up toggle on the default instance; AND and XOR directed cases alongside.
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("pwr.y@%0d", e),   y_def,   e >= 6);
      check($sformatf("pwr.chg@%0d", e), chg_def, e == 6);
      cmp_model("pwr");
      if (e == 1) d_xor = 2'b11;
      if (e >= 2) begin
        check($sformatf("xor2.y@%0d", e),   y_xor,   1'b0);
        check($sformatf("xor2.chg@%0d", e), chg_xor, 1'b0);
      end
      if (e == 2) begin
        d_and = 4'hF;
        #1 check("and.yr_f", yr_and, 1'b1);
      end
      if (e == 3) begin
        check("and.y_f",   y_and,   1'b1);
        check("and.chg_f", chg_and, 1'b1);
        d_and = 4'hE;
      end
      if (e == 4) begin
        check("and.y_e",   y_and,   1'b0);
        check("and.chg_e", chg_and, 1'b1);
      end
      if (e == 5) check("and.chg_idle", chg_and, 1'b0);
    end

    // XOR single-input flip does qualify.
    d_xor = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("xor1.y@%0d", k),   y_xor,   k >= 6);
      check($sformatf("xor1.chg@%0d", k), chg_xor, k == 6);
      cmp_model("xorphase");
    end

    // Three-cycle pulse is filtered out.
    nchg  = 0;
    d_def = 3'b111;
    for (int k = 1; k <= 11; k++) begin
      step();
      cmp_model("p3");
      nchg += int'(chg_def);
      if (k == 3) d_def = 3'b000;
    end
    check_int("p3.nchg", nchg, 0);
    check("p3.y", y_def, 1'b1);

    // Four-cycle pulse toggles Y exactly once within the window.
    nchg  = 0;
    d_def = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      step();
      cmp_model("p4");
      nchg += int'(chg_def);
      if (k == 4) d_def = 3'b000;
    end
    check_int("p4.nchg", nchg, 1);
    check("p4.y", y_def, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      cmp_model("p4ret");
    end
    check("p4ret.y", y_def, 1'b1);

    // Clock enable low freezes Y while the synchroniser keeps sampling.
    ce    = 1'b0;
    d_def = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("ce0.y@%0d", k),   y_def,   1'b1);
      check($sformatf("ce0.chg@%0d", k), chg_def, 1'b0);
      cmp_model("ce0");
    end
    ce = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("ce1.y@%0d", k),   y_def,   k < 4);
      check($sformatf("ce1.chg@%0d", k), chg_def, k == 4);
      cmp_model("ce1");
    end
    d_def = 3'b000;
    for (int k = 1; k <= 7; k++) begin
      step();
      cmp_model("ceret");
    end
    check("ceret.y", y_def, 1'b1);

    // Reset during qualification (cnt = 2) clears Y without a clock edge.
    d_def = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      step();
      cmp_model("midq");
    end
    check("midq.pre_y", y_def, 1'b1);
    #2 rn = 1'b0;
    #1;
    check("midq.rst_y",   y_def,   1'b0);
    check("midq.rst_chg", chg_def, 1'b0);
    check("midq.rst_yr",  yr_def,  1'b1);
    model_reset();
    d_def = 3'b000;
    @(negedge clk);
    rn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("rel.y@%0d", e),   y_def,   e >= 6);
      check($sformatf("rel.chg@%0d", e), chg_def, e == 6);
      cmp_model("rel");
    end

    // Randomized traffic, biased toward the two quiet patterns so toggles happen.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       d_def = 3'b000;
        1:       d_def = 3'b111;
        default: d_def = 3'($urandom_range(0, 7));
      endcase
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        ce = ($urandom_range(0, 7) != 0);
        step();
        cmp_model("rnd");
      end
    end
    ce = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
